bp_cce_gpr_wr_arb: RTL and testbench

//  Arbitrates the single CCE GPR write port between microcode writes and

---
 rtl/bp_cce_pkg.sv | 11 +
 rtl/bp_cce_gpr_wr_fifo.sv | 83 ++++++++
 rtl/bp_cce_gpr_wr_arb.sv | 130 +++++++++++++
 tb/tb_bp_cce_gpr_wr_arb.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/bp_cce_pkg.sv
// Shared types and helpers for the CCE GPR write arbiter.
package bp_cce_pkg;

  typedef enum logic {e_gpr_arb_normal, e_gpr_arb_drain} bp_cce_gpr_arb_state_e;

  // clog2 that never returns 0, so single-element selects still get a 1-bit field
  function automatic int safe_clog2(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bp_cce_gpr_wr_fifo.sv
// Small circular queue of pending directory GPR writes {sel, data}.
// Head is read combinationally; every entry's sel is exported for hazard tracking.
module bp_cce_gpr_wr_fifo
  import bp_cce_pkg::*;
#(
  parameter int els_p        = 2,
  parameter int sel_width_p  = 3,
  parameter int data_width_p = 64,
  localparam int lg_els_lp   = safe_clog2(els_p),
  localparam int cnt_width_lp = safe_clog2(els_p) + 1
) (
  input  logic                                    clk_i,
  input  logic                                    reset_i,
  input  logic                                    enq_i,
  input  logic [sel_width_p-1:0]                  enq_sel_i,
  input  logic [data_width_p-1:0]                 enq_data_i,
  input  logic                                    deq_i,
  output logic [els_p-1:0]                        valid_o,
  output logic [els_p-1:0][sel_width_p-1:0]       sels_o,
  output logic [sel_width_p-1:0]                  head_sel_o,
  output logic [data_width_p-1:0]                 head_data_o,
  output logic [cnt_width_lp-1:0]                 count_o
);

  localparam logic [lg_els_lp-1:0] last_ptr_lp = lg_els_lp'(els_p - 1);

  logic [sel_width_p-1:0]  sel_mem  [els_p];
  logic [data_width_p-1:0] data_mem [els_p];

  logic [lg_els_lp-1:0]    rptr_q, rptr_d, wptr_q, wptr_d;
  logic [cnt_width_lp-1:0] count_q, count_d;
  logic [els_p-1:0]        valid_q, valid_d;

  // Dequeue clears before enqueue sets, so enq+deq on the same slot when full keeps it valid
  always_comb begin
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    valid_d = valid_q;
    count_d = count_q + cnt_width_lp'(enq_i) - cnt_width_lp'(deq_i);
    if (deq_i) begin
      valid_d[rptr_q] = 1'b0;
      rptr_d          = (rptr_q == last_ptr_lp) ? '0 : rptr_q + 1'b1;
    end
    if (enq_i) begin
      valid_d[wptr_q] = 1'b1;
      wptr_d          = (wptr_q == last_ptr_lp) ? '0 : wptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (enq_i) begin
      sel_mem[wptr_q]  <= enq_sel_i;
      data_mem[wptr_q] <= enq_data_i;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < els_p; gi++) begin : g_sel
      assign sels_o[gi] = sel_mem[gi];
    end
  endgenerate

  assign valid_o     = valid_q;
  assign head_sel_o  = sel_mem[rptr_q];
  assign head_data_o = data_mem[rptr_q];
  assign count_o     = count_q;

endmodule

// File: rtl/bp_cce_gpr_wr_arb.sv
// Single GPR write port shared by microcode and queued/bypassed directory writes,
// with a drain FSM that empties the queue once it fills.
module bp_cce_gpr_wr_arb
  import bp_cce_pkg::*;
#(
  parameter int num_gpr_p    = 8,
  parameter int gpr_width_p  = 64,
  parameter int dir_els_p    = 2,
  localparam int lg_num_gpr_lp = safe_clog2(num_gpr_p),
  localparam int cnt_width_lp  = safe_clog2(dir_els_p) + 1
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic                     ucode_w_v_i,
  input  logic [num_gpr_p-1:0]     ucode_w_mask_i,
  input  logic [gpr_width_p-1:0]   ucode_w_data_i,
  output logic                     ucode_stall_o,
  input  logic                     dir_v_i,
  input  logic [lg_num_gpr_lp-1:0] dir_gpr_sel_i,
  input  logic [gpr_width_p-1:0]   dir_data_i,
  output logic                     dir_ready_o,
  output logic [num_gpr_p-1:0]     gpr_w_mask_o,
  output logic [gpr_width_p-1:0]   gpr_w_data_o,
  output logic [num_gpr_p-1:0]     pending_o,
  output logic                     drain_o
);

  localparam logic [num_gpr_p-1:0] one_lp = num_gpr_p'(1);

  bp_cce_gpr_arb_state_e state_q, state_d;

  logic [dir_els_p-1:0]                    fifo_valid;
  logic [dir_els_p-1:0][lg_num_gpr_lp-1:0] fifo_sels;
  logic [lg_num_gpr_lp-1:0]                head_sel;
  logic [gpr_width_p-1:0]                  head_data;
  logic [cnt_width_lp-1:0]                 count;
  logic fifo_enq, fifo_deq, bypass, fifo_empty, fifo_full, hazard;

  bp_cce_gpr_wr_fifo #(
    .els_p       (dir_els_p),
    .sel_width_p (lg_num_gpr_lp),
    .data_width_p(gpr_width_p)
  ) fifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .enq_i      (fifo_enq),
    .enq_sel_i  (dir_gpr_sel_i),
    .enq_data_i (dir_data_i),
    .deq_i      (fifo_deq),
    .valid_o    (fifo_valid),
    .sels_o     (fifo_sels),
    .head_sel_o (head_sel),
    .head_data_o(head_data),
    .count_o    (count)
  );

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == cnt_width_lp'(dir_els_p));

  logic [num_gpr_p-1:0] entry_mask [dir_els_p];
  genvar gi;
  generate
    for (gi = 0; gi < dir_els_p; gi++) begin : g_pend
      assign entry_mask[gi] = fifo_valid[gi] ? (one_lp << fifo_sels[gi]) : '0;
    end
  endgenerate

  always_comb begin
    pending_o = '0;
    for (int i = 0; i < dir_els_p; i++) pending_o = pending_o | entry_mask[i];
  end

  assign hazard  = ucode_w_v_i & |(ucode_w_mask_i & pending_o);
  assign drain_o = (state_q == e_gpr_arb_drain);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) state_q <= e_gpr_arb_normal;
    else         state_q <= state_d;
  end

  // Drain is entered on the edge that makes the queue full and left on the edge that empties it
  always_comb begin
    state_d = state_q;
    case (state_q)
      e_gpr_arb_normal:
        if (fifo_enq && !fifo_deq && count == cnt_width_lp'(dir_els_p - 1))
          state_d = e_gpr_arb_drain;
      e_gpr_arb_drain:
        if (count == cnt_width_lp'(1)) state_d = e_gpr_arb_normal;
      default: state_d = e_gpr_arb_normal;
    endcase
  end

  always_comb begin
    gpr_w_mask_o  = '0;
    gpr_w_data_o  = '0;
    ucode_stall_o = 1'b0;
    dir_ready_o   = 1'b0;
    fifo_deq      = 1'b0;
    fifo_enq      = 1'b0;
    bypass        = 1'b0;
    case (state_q)
      e_gpr_arb_normal: begin
        dir_ready_o = ~fifo_full;
        if (!fifo_empty && (!ucode_w_v_i || hazard)) begin
          fifo_deq      = 1'b1;
          gpr_w_mask_o  = one_lp << head_sel;
          gpr_w_data_o  = head_data;
          ucode_stall_o = ucode_w_v_i;
        end else if (ucode_w_v_i) begin
          gpr_w_mask_o  = ucode_w_mask_i;
          gpr_w_data_o  = ucode_w_data_i;
        end else if (fifo_empty && dir_v_i) begin
          bypass        = 1'b1;
          gpr_w_mask_o  = one_lp << dir_gpr_sel_i;
          gpr_w_data_o  = dir_data_i;
        end
        fifo_enq = dir_v_i & dir_ready_o & ~bypass;
      end
      e_gpr_arb_drain: begin
        fifo_deq      = 1'b1;
        gpr_w_mask_o  = one_lp << head_sel;
        gpr_w_data_o  = head_data;
        ucode_stall_o = ucode_w_v_i;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_bp_cce_gpr_wr_arb.sv
// Vector table plus write scoreboard for the CCE GPR write arbiter.
module tb_bp_cce_gpr_wr_arb;
  import bp_cce_pkg::*;

  logic        clk_i = 1'b0;
  logic        reset_i;
  logic        ucode_w_v_i;
  logic [7:0]  ucode_w_mask_i;
  logic [63:0] ucode_w_data_i;
  logic        ucode_stall_o;
  logic        dir_v_i;
  logic [2:0]  dir_gpr_sel_i;
  logic [63:0] dir_data_i;
  logic        dir_ready_o;
  logic [7:0]  gpr_w_mask_o;
  logic [63:0] gpr_w_data_o;
  logic [7:0]  pending_o;
  logic        drain_o;

  int checks = 0;
  int errors = 0;

  bp_cce_gpr_wr_arb #(.num_gpr_p(8), .gpr_width_p(64), .dir_els_p(2)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .ucode_w_v_i(ucode_w_v_i), .ucode_w_mask_i(ucode_w_mask_i),
    .ucode_w_data_i(ucode_w_data_i), .ucode_stall_o(ucode_stall_o),
    .dir_v_i(dir_v_i), .dir_gpr_sel_i(dir_gpr_sel_i), .dir_data_i(dir_data_i),
    .dir_ready_o(dir_ready_o), .gpr_w_mask_o(gpr_w_mask_o),
    .gpr_w_data_o(gpr_w_data_o), .pending_o(pending_o), .drain_o(drain_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        uv;  logic [7:0] umask; logic [63:0] udata;
    logic        dv;  logic [2:0] dsel;  logic [63:0] ddata;
    logic [7:0]  e_mask; logic [63:0] e_data;
    logic        e_stall; logic e_ready; logic [7:0] e_pend; logic e_drain;
  } vec_t;

  typedef struct { logic [7:0] mask; logic [63:0] data; } wr_t;

  vec_t vecs[$];
  wr_t  exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic uv, input logic [7:0] umask, input logic [63:0] udata,
                     input logic dv, input logic [2:0] dsel, input logic [63:0] ddata,
                     input logic [7:0] e_mask, input logic [63:0] e_data,
                     input logic e_stall, input logic e_ready,
                     input logic [7:0] e_pend, input logic e_drain);
    vec_t v;
    v.uv = uv; v.umask = umask; v.udata = udata;
    v.dv = dv; v.dsel = dsel; v.ddata = ddata;
    v.e_mask = e_mask; v.e_data = e_data; v.e_stall = e_stall;
    v.e_ready = e_ready; v.e_pend = e_pend; v.e_drain = e_drain;
    vecs.push_back(v);
  endtask

  task automatic drive_idle();
    ucode_w_v_i = 0; ucode_w_mask_i = '0; ucode_w_data_i = '0;
    dir_v_i = 0; dir_gpr_sel_i = '0; dir_data_i = '0;
  endtask

  task automatic drive(input logic uv, input logic [7:0] umask, input logic [63:0] udata,
                       input logic dv, input logic [2:0] dsel, input logic [63:0] ddata);
    ucode_w_v_i = uv; ucode_w_mask_i = umask; ucode_w_data_i = udata;
    dir_v_i = dv; dir_gpr_sel_i = dsel; dir_data_i = ddata;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, " mask"},    64'(gpr_w_mask_o), 64'h0);
    chk({tag, " pending"}, 64'(pending_o),    64'h0);
    chk({tag, " ready"},   64'(dir_ready_o),  64'h1);
    chk({tag, " drain"},   64'(drain_o),      64'h0);
    chk({tag, " stall"},   64'(ucode_stall_o), 64'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    wr_t w;
    reset_i = 1'b1;
    drive_idle();

    // Columns: uv umask udata | dv dsel ddata | exp mask data stall ready pending drain
    add(0, 8'h00, 64'h0,    0, 3'd0, 64'h0,    8'h00, 64'h0,    0, 1, 8'h00, 0);
    add(0, 8'h00, 64'h0,    1, 3'd3, 64'h80,   8'h08, 64'h80,   0, 1, 8'h00, 0); // bypass
    add(0, 8'h00, 64'h0,    0, 3'd0, 64'h0,    8'h00, 64'h0,    0, 1, 8'h00, 0);
    add(1, 8'h01, 64'h1111, 1, 3'd5, 64'h5555, 8'h01, 64'h1111, 0, 1, 8'h00, 0);
    add(0, 8'h00, 64'h0,    0, 3'd0, 64'h0,    8'h20, 64'h5555, 0, 1, 8'h20, 0);
    add(0, 8'h00, 64'h0,    0, 3'd0, 64'h0,    8'h00, 64'h0,    0, 1, 8'h00, 0);
    add(1, 8'h02, 64'h0101, 1, 3'd2, 64'h2222, 8'h02, 64'h0101, 0, 1, 8'h00, 0);
    add(1, 8'h04, 64'h4444, 0, 3'd0, 64'h0,    8'h04, 64'h2222, 1, 1, 8'h04, 0); // hazard
    add(1, 8'h04, 64'h4444, 0, 3'd0, 64'h0,    8'h04, 64'h4444, 0, 1, 8'h00, 0);
    add(1, 8'h01, 64'h9,    1, 3'd6, 64'h66,   8'h01, 64'h9,    0, 1, 8'h00, 0);
    add(1, 8'h02, 64'hA,    1, 3'd7, 64'h77,   8'h02, 64'hA,    0, 1, 8'h40, 0); // fills
    add(1, 8'h08, 64'hB,    1, 3'd1, 64'h11,   8'h40, 64'h66,   1, 0, 8'hC0, 1);
    add(1, 8'h08, 64'hB,    1, 3'd1, 64'h11,   8'h80, 64'h77,   1, 0, 8'h80, 1);
    add(1, 8'h08, 64'hB,    1, 3'd1, 64'h11,   8'h08, 64'hB,    0, 1, 8'h00, 0);
    add(0, 8'h00, 64'h0,    1, 3'd3, 64'h33,   8'h02, 64'h11,   0, 1, 8'h02, 0); // enq+deq
    add(0, 8'h00, 64'h0,    0, 3'd0, 64'h0,    8'h08, 64'h33,   0, 1, 8'h08, 0);
    add(0, 8'h00, 64'h0,    0, 3'd0, 64'h0,    8'h00, 64'h0,    0, 1, 8'h00, 0);
    add(1, 8'h01, 64'hC,    1, 3'd4, 64'h41,   8'h01, 64'hC,    0, 1, 8'h00, 0);
    add(1, 8'h01, 64'hD,    1, 3'd4, 64'h42,   8'h01, 64'hD,    0, 1, 8'h10, 0); // dup sel
    add(0, 8'h00, 64'h0,    1, 3'd0, 64'h99,   8'h10, 64'h41,   0, 0, 8'h10, 1);
    add(0, 8'h00, 64'h0,    0, 3'd0, 64'h0,    8'h10, 64'h42,   0, 0, 8'h10, 1);
    add(0, 8'h00, 64'h0,    0, 3'd0, 64'h0,    8'h00, 64'h0,    0, 1, 8'h00, 0);

    // Reset state, then reset asserted mid-cycle with a write queued
    repeat (2) @(negedge clk_i);
    #2 chk_idle_outputs("reset");
    reset_i = 1'b0;
    @(negedge clk_i);
    drive(1, 8'h01, 64'h1, 1, 3'd5, 64'h55);
    @(negedge clk_i);
    drive_idle();
    #2 chk("pre_reset pending", 64'(pending_o), 64'h20);
    chk("pre_reset mask", 64'(gpr_w_mask_o), 64'h20);
    #1 reset_i = 1'b1;
    #1 chk_idle_outputs("midcycle_reset");
    @(negedge clk_i);
    reset_i = 1'b0;
    #2 chk("post_reset mask", 64'(gpr_w_mask_o), 64'h0);
    $display("seq reset_midcycle done");

    foreach (vecs[i]) begin
      @(negedge clk_i);
      drive(vecs[i].uv, vecs[i].umask, vecs[i].udata, vecs[i].dv, vecs[i].dsel, vecs[i].ddata);
      if (vecs[i].e_mask != 8'h0) begin
        w.mask = vecs[i].e_mask; w.data = vecs[i].e_data;
        exp_q.push_back(w);
      end
      #2;
      chk($sformatf("v%0d mask", i),    64'(gpr_w_mask_o),  64'(vecs[i].e_mask));
      chk($sformatf("v%0d stall", i),   64'(ucode_stall_o), 64'(vecs[i].e_stall));
      chk($sformatf("v%0d ready", i),   64'(dir_ready_o),   64'(vecs[i].e_ready));
      chk($sformatf("v%0d pending", i), 64'(pending_o),     64'(vecs[i].e_pend));
      chk($sformatf("v%0d drain", i),   64'(drain_o),       64'(vecs[i].e_drain));
      if (gpr_w_mask_o != 8'h0) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("v%0d unexpected write", i), 64'(gpr_w_mask_o), 64'h0);
        end else begin
          w = exp_q.pop_front();
          chk($sformatf("v%0d sb mask", i), 64'(gpr_w_mask_o), 64'(w.mask));
          chk($sformatf("v%0d sb data", i), gpr_w_data_o, w.data);
        end
      end
      $display("vec %0d: uv=%0b dv=%0b mask=%02h data=%0h stall=%0b ready=%0b pend=%02h drain=%0b",
               i, ucode_w_v_i, dir_v_i, gpr_w_mask_o, gpr_w_data_o,
               ucode_stall_o, dir_ready_o, pending_o, drain_o);
    end
    chk("scoreboard leftover", 64'(exp_q.size()), 64'h0);

    // Reset while draining two queued writes: nothing may be written afterwards
    @(negedge clk_i);
    drive(1, 8'h01, 64'h1, 1, 3'd2, 64'h222);
    @(negedge clk_i);
    drive(1, 8'h01, 64'h2, 1, 3'd3, 64'h333);
    @(negedge clk_i);
    drive_idle();
    #2 chk("drain6 drain", 64'(drain_o), 64'h1);
    chk("drain6 pending", 64'(pending_o), 64'h0C);
    chk("drain6 mask", 64'(gpr_w_mask_o), 64'h04);
    #1 reset_i = 1'b1;
    #1 chk_idle_outputs("drain_reset");
    @(negedge clk_i);
    reset_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      #2;
      chk($sformatf("after_drain_reset c%0d mask", c), 64'(gpr_w_mask_o), 64'h0);
      chk($sformatf("after_drain_reset c%0d pending", c), 64'(pending_o), 64'h0);
      chk($sformatf("after_drain_reset c%0d drain", c), 64'(drain_o), 64'h0);
    end
    $display("seq reset_during_drain done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
